// File: rtl/div_correct.sv
// Post-correction stage for the Goldschmidt divider: rebuilds q*d by shift-add,
// compares against n, applies at most one +/-1 ulp fix and reports the remainder.
module div_correct #(
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    input  logic [WIDTH-1:0] quotient,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, CHK, FIX} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] n_reg, d_reg, q_reg;
    logic [PW-1:0]    p_reg;
    logic [PW-1:0]    md_reg;
    logic [CW-1:0]    cnt_reg;
    logic signed [PW:0] r_reg;
    logic             neg_reg, over_reg;

    logic [WIDTH-1:0] q_out_reg, rem_reg;
    logic             err_reg, done_reg;

    // Residual check: n is scaled so both operands share 2^-(2*WIDTH-4) units.
    logic [PW-1:0]      n_scaled;
    logic signed [PW:0] chk_r;
    logic signed [PW:0] d_ext;
    logic               chk_neg, chk_over;

    assign n_scaled = {2'b00, n_reg, {(WIDTH-2){1'b0}}};
    assign chk_r    = $signed({1'b0, n_scaled}) - $signed({1'b0, p_reg});
    assign d_ext    = $signed({{(WIDTH+1){1'b0}}, d_reg});
    assign chk_neg  = chk_r[PW];
    assign chk_over = !chk_neg && (chk_r[PW-1:0] >= {{WIDTH{1'b0}}, d_reg});

    logic [WIDTH-1:0]   fix_q;
    logic signed [PW:0] fix_r;
    logic               fix_err;

    always_comb begin
        fix_q   = q_reg;
        fix_r   = r_reg;
        fix_err = 1'b0;
        if (d_reg == '0) begin
            fix_r   = '0;
            fix_err = 1'b1;
        end else begin
            // Saturate rather than wrap at the ends of the quotient range.
            if (neg_reg) begin
                if (q_reg == '0) begin
                    fix_err = 1'b1;
                end else begin
                    fix_q = q_reg - WIDTH'(1);
                    fix_r = r_reg + d_ext;
                end
            end else if (over_reg) begin
                if (q_reg == {WIDTH{1'b1}}) begin
                    fix_err = 1'b1;
                end else begin
                    fix_q = q_reg + WIDTH'(1);
                    fix_r = r_reg - d_ext;
                end
            end
            if (fix_r[PW] || (fix_r[PW-1:0] >= {{WIDTH{1'b0}}, d_reg}))
                fix_err = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = MUL;
            MUL:  if (cnt_reg == LAST_BIT) state_next = CHK;
            CHK:  state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_reg     <= '0;
            d_reg     <= '0;
            q_reg     <= '0;
            p_reg     <= '0;
            md_reg    <= '0;
            cnt_reg   <= '0;
            r_reg     <= '0;
            neg_reg   <= 1'b0;
            over_reg  <= 1'b0;
            q_out_reg <= '0;
            rem_reg   <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg   <= numerator;
                        d_reg   <= denominator;
                        q_reg   <= quotient;
                        p_reg   <= '0;
                        md_reg  <= {{WIDTH{1'b0}}, denominator};
                        cnt_reg <= '0;
                    end
                end
                MUL: begin
                    // md_reg tracks d << cnt_reg, so each step is a plain add.
                    if (q_reg[cnt_reg])
                        p_reg <= p_reg + md_reg;
                    md_reg  <= md_reg << 1;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                CHK: begin
                    r_reg    <= chk_r;
                    neg_reg  <= chk_neg;
                    over_reg <= chk_over;
                end
                FIX: begin
                    q_out_reg <= fix_q;
                    rem_reg   <= fix_r[WIDTH-1:0];
                    err_reg   <= fix_err;
                    done_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state_reg == IDLE);
    assign done      = done_reg;
    assign q_out     = q_out_reg;
    assign remainder = rem_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_div_correct.sv
// Bench for div_correct at WIDTH=8: vector table plus reset, busy-start and
// back-to-back sequences, all checked through a scoreboard of expected results.
module tb_div_correct;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] numerator, denominator, quotient;
    logic         ready, done, err;
    logic [W-1:0] q_out, remainder;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    div_correct #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .numerator(numerator), .denominator(denominator), .quotient(quotient),
        .ready(ready), .done(done), .q_out(q_out), .remainder(remainder), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] n, d, q, eq, er;
        logic         ee, cr;
    } vec_t;

    typedef struct {
        logic [W-1:0] eq, er;
        logic         ee, cr;
        int           due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q_out", 32'(q_out), 32'(e.eq));
                chk("err", 32'(err), 32'(e.ee));
                if (e.cr) chk("remainder", 32'(remainder), 32'(e.er));
                chk("latency", 32'(cyc), 32'(e.due));
                $display("result q_out=0x%02h rem=0x%02h err=%0d cycle=%0d", q_out, remainder, err, cyc);
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] q,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ee, input logic cr);
        exp_t e;
        numerator   = n;
        denominator = d;
        quotient    = q;
        start       = 1'b1;
        e.eq = eq; e.er = er; e.ee = ee; e.cr = cr;
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        $display("issue n=0x%02h d=0x%02h q=0x%02h", n, d, q);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * LAT; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * LAT);
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b1; start = 1'b0;
        numerator = '0; denominator = '0; quotient = '0;

        vecs.push_back('{8'h60, 8'h40, 8'h60, 8'h60, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h60, 8'h40, 8'h61, 8'h60, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h60, 8'h40, 8'h5F, 8'h60, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h40, 8'h60, 8'h2A, 8'h2A, 8'h40, 1'b0, 1'b1});
        vecs.push_back('{8'h40, 8'h60, 8'h2C, 8'h2B, 8'hE0, 1'b1, 1'b1});
        vecs.push_back('{8'h20, 8'h00, 8'h11, 8'h11, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h30, 8'h50, 8'h26, 8'h26, 8'h20, 1'b0, 1'b1});
        vecs.push_back('{8'h30, 8'h50, 8'h27, 8'h26, 8'h20, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'h80, 8'hFF, 8'hFE, 8'hC0, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q_out", 32'(q_out), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].eq, vecs[i].er, vecs[i].ee, vecs[i].cr);
            chk("busy_ready", 32'(ready), 32'd0);
            wait_done();
            @(negedge clk);
        end

        // Results hold after the done pulse.
        repeat (3) @(negedge clk);
        chk("hold_q_out", 32'(q_out), 32'hFF);
        chk("hold_err", 32'(err), 32'd1);

        // Back-to-back: second start lands in the done cycle of the first.
        issue(8'h40, 8'h60, 8'h2A, 8'h2A, 8'h40, 1'b0, 1'b1);
        wait_done();
        chk("b2b_ready_in_done", 32'(ready), 32'd1);
        issue(8'h40, 8'h60, 8'h2B, 8'h2A, 8'h40, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // A start pulse while busy must be ignored (no extra done).
        issue(8'h60, 8'h40, 8'h60, 8'h60, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        numerator = 8'h11; denominator = 8'h22; quotient = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2 * LAT) @(negedge clk);

        // Reset at MUL cycle 4 discards the operation.
        issue(8'h40, 8'h60, 8'h2A, 8'h2A, 8'h40, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("mid_reset_ready", 32'(ready), 32'd1);
        chk("mid_reset_done", 32'(done), 32'd0);
        chk("mid_reset_q_out", 32'(q_out), 32'd0);
        chk("mid_reset_remainder", 32'(remainder), 32'd0);
        chk("mid_reset_err", 32'(err), 32'd0);
        repeat (2 * LAT) @(negedge clk);

        issue(8'h30, 8'h50, 8'h26, 8'h26, 8'h20, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

endmodule
